// File: rtl/ifu_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave):
// a request channel (valid/ready/addr) and a response channel (valid/data/err).
interface ifu_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [INST_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: owns the PC, fetches one instruction at a time,
// hands {inst, pc_out} to decode and commits the next PC on acceptance.
module ifu_fetch #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_w_en,
  input  logic              halt,
  ifu_fetch_if.master       imem,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        err_code,
  output logic              halted,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ACCESS   = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } err_e;

  state_e state;

  // The request address is the PC itself, so it is stable for as long as REQ lasts.
  assign imem.req_addr = pc_out;

  // NOTE: every register here is written with <= so all updates in a cycle see
  // the pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      pc_out         <= RESET_PC;
      inst           <= '0;
      err_code       <= ERR_NONE;
      retire_cnt     <= '0;
      inst_valid     <= 1'b0;
      halted         <= 1'b0;
      imem.req_valid <= 1'b1;
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem.req_ready) begin
            imem.req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem.rsp_valid) begin
            if (imem.rsp_err) begin
              err_code <= ERR_ACCESS;
              halted   <= 1'b1;
              state    <= S_ERR;
            end else begin
              inst       <= imem.rsp_data;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            // Faulting accepts leave the PC on the offending instruction for debug.
            if (!pc_w_en) begin
              err_code <= ERR_ILLEGAL;
              halted   <= 1'b1;
              state    <= S_ERR;
            end else if (pc_in[1:0] != 2'b00) begin
              err_code <= ERR_MISALIGN;
              halted   <= 1'b1;
              state    <= S_ERR;
            end else begin
              pc_out     <= pc_in;
              retire_cnt <= retire_cnt + 32'd1;
              if (halt) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                imem.req_valid <= 1'b1;
                state          <= S_REQ;
              end
            end
          end
        end

        S_HALT, S_ERR: begin
          // Terminal until reset.
        end

        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized run, all
// checked against a transaction-level model of PC, retire count and fault state.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_w_en;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic [1:0]  err_code;
  logic        halted;
  logic [31:0] retire_cnt;

  ifu_fetch_if #(.ADDR_W(32), .INST_W(32)) imem ();

  ifu_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_w_en    (pc_w_en),
    .halt       (halt),
    .imem       (imem.master),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc_out     (pc_out),
    .err_code   (err_code),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view only.
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  logic [1:0]  m_err;
  logic        m_halted;

  task automatic idle_inputs();
    pc_in          = $urandom;
    pc_w_en        = 1'b0;
    halt           = 1'b0;
    inst_ready     = 1'b0;
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = $urandom;
    imem.rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    m_pc     = RESET_PC;
    m_retire = 32'd0;
    m_err    = 2'd0;
    m_halted = 1'b0;
  endtask

  // One full instruction; called at a negedge with the DUT in REQ.
  task automatic run_instr(input int req_stall, input int rsp_delay, input logic [31:0] data,
                           input logic rsp_err, input int hold_stall, input logic wen,
                           input logic [31:0] pcin, input logic hlt);
    for (int i = 0; i < req_stall; i++) begin
      imem.req_ready = 1'b0;
      checks++;
      if ({imem.req_valid, imem.req_addr} !== {1'b1, m_pc}) begin
        errors++;
        $display("FAIL req_stall: valid=%0b addr=%h, want valid=1 addr=%h",
                 imem.req_valid, imem.req_addr, m_pc);
      end
      @(negedge clk);
    end
    checks++;
    if ({imem.req_valid, imem.req_addr} !== {1'b1, m_pc}) begin
      errors++;
      $display("FAIL req_issue: valid=%0b addr=%h, want valid=1 addr=%h",
               imem.req_valid, imem.req_addr, m_pc);
    end
    imem.req_ready = 1'b1;
    @(negedge clk);
    imem.req_ready = $urandom_range(0, 1);
    for (int i = 0; i <= rsp_delay; i++) begin
      checks++;
      if ({imem.req_valid, inst_valid, halted} !== 3'b000) begin
        errors++;
        $display("FAIL wait: req_valid=%0b inst_valid=%0b halted=%0b, want 0 0 0",
                 imem.req_valid, inst_valid, halted);
      end
      if (i < rsp_delay) @(negedge clk);
    end
    imem.rsp_valid = 1'b1;
    imem.rsp_data  = data;
    imem.rsp_err   = rsp_err;
    @(negedge clk);
    imem.rsp_valid = 1'b0;
    imem.rsp_err   = 1'b0;
    imem.rsp_data  = $urandom;
    if (rsp_err) begin
      m_err    = 2'd1;
      m_halted = 1'b1;
      checks++;
      if ({halted, err_code, inst_valid, imem.req_valid, pc_out} !== {1'b1, 2'd1, 2'b00, m_pc}) begin
        errors++;
        $display("FAIL access_fault: halted=%0b err=%0d iv=%0b rv=%0b pc=%h, want 1 1 0 0 %h",
                 halted, err_code, inst_valid, imem.req_valid, pc_out, m_pc);
      end
      return;
    end
    for (int i = 0; i <= hold_stall; i++) begin
      checks++;
      if ({inst_valid, inst, pc_out, imem.req_valid, retire_cnt} !== {1'b1, data, m_pc, 1'b0, m_retire}) begin
        errors++;
        $display("FAIL hold: iv=%0b inst=%h pc=%h rv=%0b ret=%0d, want 1 %h %h 0 %0d",
                 inst_valid, inst, pc_out, imem.req_valid, retire_cnt, data, m_pc, m_retire);
      end
      if (i < hold_stall) begin
        // Side inputs are don't-care outside an accept.
        pc_w_en = $urandom_range(0, 1);
        pc_in   = $urandom;
        halt    = $urandom_range(0, 1);
        imem.rsp_valid = $urandom_range(0, 1);
        @(negedge clk);
        imem.rsp_valid = 1'b0;
      end
    end
    inst_ready = 1'b1;
    pc_w_en    = wen;
    pc_in      = pcin;
    halt       = hlt;
    @(negedge clk);
    inst_ready = 1'b0;
    pc_w_en    = 1'b0;
    halt       = 1'b0;
    if (!wen) begin
      m_err = 2'd3; m_halted = 1'b1;
    end else if (pcin[1:0] != 2'b00) begin
      m_err = 2'd2; m_halted = 1'b1;
    end else begin
      m_pc     = pcin;
      m_retire = m_retire + 32'd1;
      m_halted = hlt;
    end
    checks++;
    if ({pc_out, retire_cnt, err_code, halted, inst_valid, imem.req_valid} !==
        {m_pc, m_retire, m_err, m_halted, 1'b0, !m_halted}) begin
      errors++;
      $display("FAIL accept: pc=%h ret=%0d err=%0d halted=%0b iv=%0b rv=%0b, want %h %0d %0d %0b 0 %0b",
               pc_out, retire_cnt, err_code, halted, inst_valid, imem.req_valid,
               m_pc, m_retire, m_err, m_halted, !m_halted);
    end
  endtask

  task automatic test_frozen(input string tag);
    for (int i = 0; i < 6; i++) begin
      imem.req_ready = $urandom_range(0, 1);
      imem.rsp_valid = $urandom_range(0, 1);
      imem.rsp_err   = $urandom_range(0, 1);
      inst_ready     = $urandom_range(0, 1);
      pc_w_en        = $urandom_range(0, 1);
      pc_in          = $urandom & 32'hFFFF_FFFC;
      halt           = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if ({imem.req_valid, inst_valid, halted, pc_out, err_code, retire_cnt} !==
          {2'b00, 1'b1, m_pc, m_err, m_retire}) begin
        errors++;
        $display("FAIL frozen_%s: rv=%0b iv=%0b halted=%0b pc=%h err=%0d ret=%0d, want 0 0 1 %h %0d %0d",
                 tag, imem.req_valid, inst_valid, halted, pc_out, err_code, retire_cnt,
                 m_pc, m_err, m_retire);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem.req_valid, imem.req_addr, pc_out, inst, err_code, retire_cnt, inst_valid, halted} !==
        {1'b1, RESET_PC, RESET_PC, 32'd0, 2'd0, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset: rv=%0b addr=%h pc=%h inst=%h err=%0d ret=%0d iv=%0b halted=%0b",
               imem.req_valid, imem.req_addr, pc_out, inst, err_code, retire_cnt, inst_valid, halted);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_instr(0, 0, 32'h0000_0413, 1'b0, 0, 1'b1, RESET_PC + 32'd4, 1'b0);
    run_instr(0, 0, 32'h0000_0413, 1'b0, 0, 1'b1, RESET_PC + 32'd8, 1'b0);
    checks++;
    if (retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL basic_retire: got %0d want 2", retire_cnt);
    end
  endtask

  task automatic test_stalls();
    do_reset();
    run_instr(3, 0, 32'h1234_5678, 1'b0, 0, 1'b1, RESET_PC + 32'd4, 1'b0);
    run_instr(0, 2, 32'hCAFE_0013, 1'b0, 5, 1'b1, 32'h8000_0100, 1'b0);
  endtask

  task automatic test_faults();
    do_reset();
    run_instr(0, 0, 32'h0000_0013, 1'b0, 0, 1'b1, 32'h8000_0006, 1'b0);
    test_frozen("misalign");
    do_reset();
    run_instr(0, 1, 32'hDEAD_BEEF, 1'b1, 0, 1'b1, 32'h0, 1'b0);
    test_frozen("access");
    do_reset();
    run_instr(0, 0, 32'h0000_0013, 1'b0, 0, 1'b1, RESET_PC + 32'd4, 1'b0);
    run_instr(0, 0, 32'h0000_0013, 1'b0, 1, 1'b0, RESET_PC + 32'd8, 1'b0);
    test_frozen("illegal");
    do_reset();
    run_instr(0, 0, 32'h0010_0073, 1'b0, 0, 1'b1, 32'h8000_0010, 1'b1);
    test_frozen("halt");
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(0, 0, 32'h0000_0013, 1'b0, 0, 1'b1, RESET_PC + 32'd4, 1'b0);
    imem.req_ready = 1'b1;
    @(negedge clk);
    imem.req_ready = 1'b0;
    rst            = 1'b1;
    imem.rsp_valid = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    imem.rsp_valid = 1'b0;
    m_pc = RESET_PC; m_retire = 32'd0; m_err = 2'd0; m_halted = 1'b0;
    checks++;
    if ({imem.req_valid, imem.req_addr, retire_cnt, inst_valid} !== {1'b1, RESET_PC, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait: rv=%0b addr=%h ret=%0d iv=%0b", imem.req_valid, imem.req_addr, retire_cnt, inst_valid);
    end
    run_instr(0, 0, 32'h0000_0013, 1'b0, 0, 1'b1, 32'h8000_0040, 1'b0);
    imem.req_ready = 1'b1;
    @(negedge clk);
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b1;
    @(negedge clk);
    imem.rsp_valid = 1'b0;
    rst            = 1'b1;
    inst_ready     = 1'b1;
    pc_w_en        = 1'b1;
    @(negedge clk);
    rst = 1'b0; inst_ready = 1'b0; pc_w_en = 1'b0;
    checks++;
    if ({imem.req_valid, imem.req_addr, retire_cnt, inst_valid, pc_out} !== {1'b1, RESET_PC, 32'd0, 1'b0, RESET_PC}) begin
      errors++;
      $display("FAIL rst_hold: rv=%0b addr=%h ret=%0d iv=%0b pc=%h",
               imem.req_valid, imem.req_addr, retire_cnt, inst_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_retire = 32'hFFFF_FFFF;
    run_instr(0, 0, 32'h0000_0013, 1'b0, 1, 1'b1, RESET_PC + 32'd4, 1'b0);
    checks++;
    if (retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap: got %h want 00000000", retire_cnt);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int n = 0; n < 25 && !m_halted; n++) begin
        int          kind;
        logic [31:0] target;
        logic        wen;
        logic        hlt;
        logic        rerr;
        kind   = $urandom_range(0, 39);
        target = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
        wen    = 1'b1;
        hlt    = 1'b0;
        rerr   = 1'b0;
        if (kind == 0) rerr = 1'b1;
        else if (kind == 1) wen = 1'b0;
        else if (kind == 2) target[1:0] = 2'($urandom_range(1, 3));
        else if (kind == 3) hlt = 1'b1;
        run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, rerr,
                  $urandom_range(0, 3), wen, target, hlt);
      end
      if (m_halted) test_frozen("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_stalls();
    test_faults();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
